// File: rtl/score_bcd_converter.sv
// Score counter with a serial double-dabble binary-to-BCD converter.
// Results are handed to a digit renderer through a one-cycle load strobe.
module score_bcd_converter #(
  parameter logic [9:0] MAX_SCORE = 10'd999
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       clear,
  input  logic       hit,
  input  logic       penalty,
  input  logic       renderer_busy,
  output logic [9:0] score,
  output logic [3:0] hundreds,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic       ld_en,
  output logic       busy,
  output logic       max_reached
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    LOAD
  } state_t;

  state_t      state;
  logic [9:0]  score_next;
  logic        score_evt;
  logic        pending;
  logic        leave_idle;
  logic [9:0]  snap;
  logic [11:0] scratch;
  logic [3:0]  cnt;
  logic [11:0] adj;
  logic [21:0] shifted;

  // Next score: clear wins, simultaneous hit/penalty cancel, both ends saturate
  always_comb begin
    score_next = score;
    if (clear) begin
      score_next = '0;
    end else if (hit && penalty) begin
      score_next = score;
    end else if (hit) begin
      if (score < MAX_SCORE) begin
        score_next = score + 10'd1;
      end
    end else if (penalty) begin
      if (score != 10'd0) begin
        score_next = score - 10'd1;
      end
    end
  end

  assign score_evt  = clear || (score_next != score);
  assign leave_idle = (state == IDLE) && pending;
  assign busy       = (state != IDLE);

  // Double-dabble step: bias nibbles >= 5 so the shift carries in decimal
  assign adj[3:0]   = (scratch[3:0] >= 4'd5)
                    ? scratch[3:0] + 4'd3 : scratch[3:0];
  assign adj[7:4]   = (scratch[7:4] >= 4'd5)
                    ? scratch[7:4] + 4'd3 : scratch[7:4];
  assign adj[11:8]  = (scratch[11:8] >= 4'd5)
                    ? scratch[11:8] + 4'd3 : scratch[11:8];
  assign shifted    = {adj, snap} << 1;

  // Score register and its saturation flag share one edge
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      score       <= '0;
      max_reached <= 1'b0;
    end else begin
      score       <= score_next;
      max_reached <= (score_next == MAX_SCORE);
    end
  end

  // Pending request: a new event beats the consume on leaving IDLE
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pending <= 1'b0;
    end else if (score_evt) begin
      pending <= 1'b1;
    end else if (leave_idle) begin
      pending <= 1'b0;
    end
  end

  // Conversion FSM: snapshot, ten shift steps, then load when renderer free
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= IDLE;
      snap     <= '0;
      scratch  <= '0;
      cnt      <= '0;
      hundreds <= '0;
      tens     <= '0;
      ones     <= '0;
      ld_en    <= 1'b0;
    end else begin
      ld_en <= 1'b0;
      unique case (state)
        IDLE: begin
          if (pending) begin
            snap    <= score;
            scratch <= '0;
            cnt     <= 4'd10;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          scratch <= shifted[21:10];
          snap    <= shifted[9:0];
          cnt     <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            state <= LOAD;
          end
        end
        LOAD: begin
          if (!renderer_busy) begin
            hundreds <= scratch[11:8];
            tens     <= scratch[7:4];
            ones     <= scratch[3:0];
            ld_en    <= 1'b1;
            state    <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_score_bcd_converter.sv
// Bench for score_bcd_converter: directed scenarios plus a random
// stream checked against a decimal-arithmetic reference model.
module tb_score_bcd_converter;

  logic       clk;
  logic       resetn;
  logic       clear;
  logic       hit;
  logic       penalty;
  logic       renderer_busy;
  logic [9:0] score;
  logic [3:0] hundreds;
  logic [3:0] tens;
  logic [3:0] ones;
  logic       ld_en;
  logic       busy;
  logic       max_reached;

  int checks;
  int failures;

  int m_score;
  bit m_pending;
  int m_phase;
  int m_left;
  int m_val;
  int m_h;
  int m_t;
  int m_o;
  bit m_ld;

  score_bcd_converter dut (
    .clk           (clk),
    .resetn        (resetn),
    .clear         (clear),
    .hit           (hit),
    .penalty       (penalty),
    .renderer_busy (renderer_busy),
    .score         (score),
    .hundreds      (hundreds),
    .tens          (tens),
    .ones          (ones),
    .ld_en         (ld_en),
    .busy          (busy),
    .max_reached   (max_reached)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    m_score   = 0;
    m_pending = 0;
    m_phase   = 0;
    m_left    = 0;
    m_val     = 0;
    m_h       = 0;
    m_t       = 0;
    m_o       = 0;
    m_ld      = 0;
  endtask

  // Reference: phase 0 idle, 1 converting (10 steps), 2 waiting on renderer
  task automatic model_edge();
    int ns;
    bit evt;
    bit leaving;
    if (!resetn) begin
      model_reset();
      return;
    end
    ns = m_score;
    if (clear) ns = 0;
    else if (hit && penalty) ns = m_score;
    else if (hit) ns = (m_score < 999) ? m_score + 1 : m_score;
    else if (penalty) ns = (m_score > 0) ? m_score - 1 : 0;
    evt = clear || (ns != m_score);
    m_ld = 0;
    leaving = 0;
    if (m_phase == 0) begin
      if (m_pending) begin
        m_val = m_score;
        m_left = 10;
        m_phase = 1;
        leaving = 1;
      end
    end else if (m_phase == 1) begin
      m_left--;
      if (m_left == 0) m_phase = 2;
    end else begin
      if (!renderer_busy) begin
        m_h = m_val / 100;
        m_t = (m_val / 10) % 10;
        m_o = m_val % 10;
        m_ld = 1;
        m_phase = 0;
      end
    end
    m_pending = evt || (m_pending && !leaving);
    m_score = ns;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle_inputs();
    clear = 0;
    hit = 0;
    penalty = 0;
  endtask

  task automatic test_reset();
    bit any_busy;
    resetn = 0;
    idle_inputs();
    renderer_busy = 0;
    model_reset();
    repeat (3) tick();
    checks++;
    if (score !== 10'd0 || ld_en !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_state score=%0d ld=%b busy=%b exp 0/0/0",
               score, ld_en, busy);
    end
    checks++;
    if ({hundreds, tens, ones} !== 12'h000 || max_reached !== 1'b0) begin
      failures++;
      $display("FAIL reset_digits got=%h max=%b exp 000/0",
               {hundreds, tens, ones}, max_reached);
    end
    resetn = 1;
    any_busy = 0;
    repeat (6) begin
      tick();
      if (busy !== 1'b0 || ld_en !== 1'b0) any_busy = 1;
    end
    checks++;
    if (any_busy) begin
      failures++;
      $display("FAIL reset_stays_idle got=active exp=idle");
    end
  endtask

  task automatic test_single_hit();
    int n;
    hit = 1;
    tick();
    hit = 0;
    checks++;
    if (score !== 10'd1) begin
      failures++;
      $display("FAIL single_score got=%0d exp=1", score);
    end
    n = 0;
    for (int i = 1; i <= 30; i++) begin
      tick();
      if (ld_en === 1'b1) begin
        n = i;
        break;
      end
    end
    checks++;
    if (n != 12) begin
      failures++;
      $display("FAIL single_latency got=%0d exp=12", n);
    end
    checks++;
    if ({hundreds, tens, ones} !== 12'h001) begin
      failures++;
      $display("FAIL single_digits got=%h exp=001",
               {hundreds, tens, ones});
    end
    tick();
    checks++;
    if (ld_en !== 1'b0) begin
      failures++;
      $display("FAIL single_pulse_width got=%b exp=0", ld_en);
    end
  endtask

  task automatic test_saturation();
    logic [11:0] last;
    hit = 1;
    for (int i = 0; i < 1200 && m_score < 998; i++) tick();
    hit = 0;
    checks++;
    if (score !== 10'd998 || max_reached !== 1'b0) begin
      failures++;
      $display("FAIL sat_preload score=%0d max=%b exp 998/0",
               score, max_reached);
    end
    hit = 1;
    repeat (3) tick();
    hit = 0;
    checks++;
    if (score !== 10'd999 || max_reached !== 1'b1) begin
      failures++;
      $display("FAIL sat_ceiling score=%0d max=%b exp 999/1",
               score, max_reached);
    end
    last = 12'hfff;
    repeat (40) begin
      tick();
      if (ld_en === 1'b1) last = {hundreds, tens, ones};
    end
    checks++;
    if (last !== 12'h999 || busy !== 1'b0) begin
      failures++;
      $display("FAIL sat_final_load got=%h busy=%b exp 999/0",
               last, busy);
    end
    clear = 1;
    tick();
    clear = 0;
    checks++;
    if (score !== 10'd0 || max_reached !== 1'b0) begin
      failures++;
      $display("FAIL sat_clear score=%0d max=%b exp 0/0",
               score, max_reached);
    end
    repeat (40) tick();
    penalty = 1;
    tick();
    penalty = 0;
    tick();
    checks++;
    if (score !== 10'd0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL floor_penalty score=%0d busy=%b exp 0/0",
               score, busy);
    end
  endtask

  task automatic test_hit_penalty();
    hit = 1;
    repeat (5) tick();
    hit = 0;
    repeat (40) tick();
    hit = 1;
    penalty = 1;
    tick();
    hit = 0;
    penalty = 0;
    checks++;
    if (score !== 10'd5) begin
      failures++;
      $display("FAIL both_score got=%0d exp=5", score);
    end
    tick();
    tick();
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL both_no_conv busy=%b exp=0", busy);
    end
  endtask

  task automatic test_renderer_busy();
    bit any_ld;
    bit moved;
    bit idle_seen;
    renderer_busy = 1;
    hit = 1;
    tick();
    hit = 0;
    repeat (11) tick();
    any_ld = 0;
    moved = 0;
    idle_seen = 0;
    repeat (20) begin
      tick();
      if (ld_en !== 1'b0) any_ld = 1;
      if ({hundreds, tens, ones} !== 12'h005) moved = 1;
      if (busy !== 1'b1) idle_seen = 1;
    end
    checks++;
    if (any_ld || moved || idle_seen) begin
      failures++;
      $display("FAIL stall_hold ld=%b moved=%b idle=%b exp 0/0/0",
               any_ld, moved, idle_seen);
    end
    renderer_busy = 0;
    tick();
    checks++;
    if (ld_en !== 1'b1 || {hundreds, tens, ones} !== 12'h006) begin
      failures++;
      $display("FAIL stall_release ld=%b dig=%h exp 1/006",
               ld_en, {hundreds, tens, ones});
    end
  endtask

  task automatic test_back_to_back();
    int pulses;
    logic [11:0] dig [2];
    clear = 1;
    tick();
    clear = 0;
    repeat (40) tick();
    pulses = 0;
    dig[0] = 12'hfff;
    dig[1] = 12'hfff;
    for (int i = 0; i < 50; i++) begin
      hit = (i < 10) && (i % 2 == 0);
      tick();
      if (ld_en === 1'b1) begin
        if (pulses < 2) dig[pulses] = {hundreds, tens, ones};
        pulses++;
      end
    end
    hit = 0;
    checks++;
    if (pulses != 2) begin
      failures++;
      $display("FAIL b2b_pulses got=%0d exp=2", pulses);
    end
    checks++;
    if (dig[0] !== 12'h001 || dig[1] !== 12'h005) begin
      failures++;
      $display("FAIL b2b_digits got=%h,%h exp=001,005",
               dig[0], dig[1]);
    end
  endtask

  task automatic test_reset_mid_shift();
    bit bad;
    hit = 1;
    tick();
    hit = 0;
    repeat (4) tick();
    resetn = 0;
    model_reset();
    #1;
    checks++;
    if (score !== 10'd0 || {hundreds, tens, ones} !== 12'h000 ||
        ld_en !== 1'b0 || busy !== 1'b0 || max_reached !== 1'b0) begin
      failures++;
      $display("FAIL abort_async score=%0d dig=%h ld=%b busy=%b exp 0",
               score, {hundreds, tens, ones}, ld_en, busy);
    end
    repeat (2) tick();
    resetn = 1;
    bad = 0;
    repeat (20) begin
      tick();
      if (ld_en !== 1'b0 || busy !== 1'b0) bad = 1;
    end
    checks++;
    if (bad) begin
      failures++;
      $display("FAIL abort_quiet got=activity exp=idle");
    end
  endtask

  task automatic test_random();
    int errs;
    errs = 0;
    for (int i = 0; i < 1500; i++) begin
      clear = ($urandom_range(63) == 0);
      hit = (i < 600) ? ($urandom_range(2) != 0)
                      : ($urandom_range(2) == 0);
      penalty = ($urandom_range(3) == 0);
      renderer_busy = ($urandom_range(2) == 0);
      tick();
      checks++;
      if (score !== m_score[9:0] ||
          max_reached !== (m_score == 999)) begin
        failures++;
        errs++;
        if (errs < 10)
          $display("FAIL rnd_score cyc=%0d got=%0d/%b exp=%0d",
                   i, score, max_reached, m_score);
      end
      checks++;
      if (busy !== (m_phase != 0) || ld_en !== m_ld) begin
        failures++;
        errs++;
        if (errs < 10)
          $display("FAIL rnd_ctrl cyc=%0d busy=%b ld=%b exp %b/%b",
                   i, busy, ld_en, m_phase != 0, m_ld);
      end
      checks++;
      if (hundreds !== m_h[3:0] || tens !== m_t[3:0] ||
          ones !== m_o[3:0]) begin
        failures++;
        errs++;
        if (errs < 10)
          $display("FAIL rnd_digits cyc=%0d got=%0d%0d%0d exp=%0d%0d%0d",
                   i, hundreds, tens, ones, m_h, m_t, m_o);
      end
    end
    idle_inputs();
    renderer_busy = 0;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    resetn = 0;
    renderer_busy = 0;
    idle_inputs();
    model_reset();
    test_reset();
    test_single_hit();
    test_saturation();
    test_hit_penalty();
    test_renderer_busy();
    test_back_to_back();
    test_reset_mid_shift();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
